mem_port_arbiter: RTL and testbench

Shares the single-ported 16-bit unified memory between the instruction-fetch stage and the data-memory stage of the pipelined core. Grants one access at a time, drives the registered memory command, and routes read data and completion pulses back to the owner. The fetch stage holds its PC while its request is ungranted. A losing requester therefore sees its stall as the absence of a grant.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and the data stage.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_grant,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_grant,
  output logic        dm_valid,
  output logic [15:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          owner_dm;
  logic          accept;
  logic          done;
  logic          fetch_forced;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] streak;

  assign fetch_forced = (streak == SW'(STARVE_MAX));

  // Counts data wins that kept a waiting fetch out; a fetch win resets it.
  always_ff @(posedge clk) begin
    if (rst)
      streak <= '0;
    else if (if_grant)
      streak <= '0;
    else if (dm_grant && if_req)
      streak <= streak + SW'(1);
  end
`else
  assign fetch_forced = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    if_grant = 1'b0;
    dm_grant = 1'b0;
    // Reset suppresses grants so nothing looks accepted in the reset cycle.
    if (state == ST_IDLE && !rst) begin
      if (if_req && (!dm_req || fetch_forced))
        if_grant = 1'b1;
      else if (dm_req)
        dm_grant = 1'b1;
    end
  end

  assign accept = if_grant | dm_grant;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner_dm  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ISSUE)
        cnt <= CW'(MEM_LATENCY - 1);
      else if (state == ST_WAIT && cnt != '0)
        cnt <= cnt - CW'(1);
      if (accept)
        owner_dm <= dm_grant;
      // The command registers hold the accepted request for exactly the ISSUE cycle.
      mem_en    <= accept;
      mem_we    <= dm_grant & dm_we;
      mem_addr  <= if_grant ? if_addr : (dm_grant ? dm_addr : '0);
      mem_wdata <= dm_grant ? dm_wdata : '0;
    end
  end

  assign done     = (state == ST_WAIT) && (cnt == '0);
  assign if_valid = done & ~owner_dm;
  assign dm_valid = done & owner_dm;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then constrained-random
// traffic, all compared against a cycle-count reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_grant, if_valid, dm_grant, dm_valid;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_grant(dm_grant), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: one transaction in flight, described by its accept cycle.
  bit          m_pend;
  int          m_acc;
  bit          m_dm, m_we;
  logic [15:0] m_addr, m_wdata;
  int          m_streak;
  bit          m_if_g, m_dm_g;
  string       hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Evaluate one clock cycle: predict, compare, advance model and clock.
  task automatic tick();
    bit issue, fin;
    #3;
    m_if_g = 1'b0;
    m_dm_g = 1'b0;
    if (rst) begin
      m_pend   = 1'b0;
      m_streak = 0;
    end else begin
      if (m_pend && cyc >= m_acc + 2 + LAT) m_pend = 1'b0;
      if (!m_pend) begin
        if (dm_req && if_req) begin
`ifdef ARB_STARVE_GUARD_EN
          if (m_streak == SMAX) m_if_g = 1'b1; else m_dm_g = 1'b1;
`else
          m_dm_g = 1'b1;
`endif
        end else if (dm_req) m_dm_g = 1'b1;
        else if (if_req)     m_if_g = 1'b1;
      end
      issue = m_pend && (cyc == m_acc + 1);
      fin   = m_pend && (cyc == m_acc + 1 + LAT);
      check("if_grant",  32'(if_grant),  32'(m_if_g));
      check("dm_grant",  32'(dm_grant),  32'(m_dm_g));
      check("mem_en",    32'(mem_en),    32'(issue));
      check("mem_we",    32'(mem_we),    32'(issue & m_we));
      check("mem_addr",  32'(mem_addr),  issue ? 32'(m_addr)  : 32'h0);
      check("mem_wdata", 32'(mem_wdata), issue ? 32'(m_wdata) : 32'h0);
      check("if_valid",  32'(if_valid),  32'(fin & !m_dm));
      check("dm_valid",  32'(dm_valid),  32'(fin & m_dm));
      check("busy",      32'(busy),      32'(m_pend));
      check("if_rdata",  32'(if_rdata),  32'(mem_rdata));
      check("dm_rdata",  32'(dm_rdata),  32'(mem_rdata));
      if (if_grant) hist = {hist, "I"};
      if (dm_grant) hist = {hist, "D"};
      if (m_if_g || m_dm_g) begin
        m_pend  = 1'b1;
        m_acc   = cyc;
        m_dm    = m_dm_g;
        m_we    = m_dm_g && dm_we;
        m_addr  = m_dm_g ? dm_addr : if_addr;
        m_wdata = m_dm_g ? dm_wdata : 16'h0;
      end
      if (m_dm_g && if_req) m_streak++;
      if (m_if_g)           m_streak = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    string exp_hist;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    m_pend = 1'b0; m_acc = 0; m_dm = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_streak = 0;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    check("rst_mem_en",   32'(mem_en),   32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_valids",   32'({if_valid, dm_valid}), 32'h0);
    tick();

    // Lone fetch
    if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'($urandom);
    tick();
    if_req = 1'b0; if_addr = '0;
    check("lone_mem_en",   32'(mem_en),   32'h1);
    check("lone_mem_addr", 32'(mem_addr), 32'h0010);
    repeat (LAT) tick();
    mem_rdata = 16'hBEEF;
    #1;
    check("lone_if_valid", 32'(if_valid), 32'h1);
    check("lone_if_rdata", 32'(if_rdata), 32'hBEEF);
    tick();
    check("lone_idle", 32'(busy), 32'h0);

    // Simultaneous requests: data first, fetch right after
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
    mem_rdata = 16'($urandom);
    tick();
    dm_req = 1'b0;
    check("sim_mem_addr", 32'(mem_addr), 32'h0200);
    repeat (LAT + 1) tick();
    #1;
    check("sim_if_grant", 32'(if_grant), 32'h1);
    tick();
    if_req = 1'b0;
    repeat (LAT + 2) tick();

    // Data write
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'h1234;
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    check("wr_mem_we",    32'(mem_we),    32'h1);
    check("wr_mem_addr",  32'(mem_addr),  32'h0300);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    repeat (LAT) tick();
    #1;
    check("wr_dm_valid", 32'(dm_valid), 32'h1);
    check("wr_if_valid", 32'(if_valid), 32'h0);
    tick();

    // Reset in the middle of WAIT
    dm_req = 1'b1; dm_addr = 16'h0400;
    tick();
    dm_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",   32'(busy),   32'h0);
    check("mid_rst_mem_en", 32'(mem_en), 32'h0);
    repeat (LAT + 2) tick();

    // Both requesters held high for eight transactions
    hist = "";
    if_req = 1'b1; if_addr = 16'h0500;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0600;
    repeat (8 * (LAT + 2)) tick();
    if_req = 1'b0; dm_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    exp_hist = "DDDIDDDI";
`else
    exp_hist = "DDDDDDDD";
`endif
    checks++;
    assert (hist == exp_hist) else begin
      errors++;
      $error("FAIL grant_order observed=%s expected=%s", hist, exp_hist);
    end
    repeat (LAT + 2) tick();

    // Random traffic obeying the hold-until-granted protocol
    for (int k = 0; k < 600; k++) begin
      mem_rdata = 16'($urandom);
      if (!if_req || m_if_g) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 16'($urandom);
      end
      if (!dm_req || m_dm_g) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (LAT + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
